// File: rtl/sensor_pkg.sv
// Shared constants for the sensor input conditioning stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package sensor_pkg;

  // Bit positions of each sensor within raw_i / clean_o / rise_o / latched_o
  localparam int SENS_ARMED  = 0;
  localparam int SENS_DOOR   = 1;
  localparam int SENS_MOTION = 2;
  localparam int SENS_TEMP   = 3;
  localparam int N_SENS      = 4;

  // Stability window used when the instantiating level does not override it
  localparam int DEFAULT_DEB_CYCLES = 16;

endpackage

// File: rtl/sensor_debounce.sv
// Single-channel conditioner: 2-flop synchroniser, debounce counter, clean level, rise pulse.
// Latency: raw change at edge k -> clean/rise at edge k+DEB_CYCLES+1.
// Backpressure: none; free-running, samples every clock.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_raw        : asynchronous sensor pin
//   o_clean      : debounced level (registered)
//   o_rise       : one-cycle pulse on clean 0->1 (registered)
//   o_rise_nxt   : value o_rise takes at the next edge (register-driven only),
//                  lets the parent update its own state on the same edge as o_rise
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_clean,
  output logic o_rise,
  output logic o_rise_nxt
);

  localparam int                CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic             r_clean;
  logic             r_rise;
  logic [CNT_W-1:0] r_cnt;

  logic w_diff;
  logic w_done;

  // Synchronised input disagrees with the clean level; count only while it does
  assign w_diff = r_s2 ^ r_clean;
  // Window complete on this edge: clean level adopts the synchronised value
  assign w_done = w_diff && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_clean <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (!w_diff) begin
        // Input back at the clean value: any partial window is discarded
        r_cnt <= '0;
      end else if (w_done) begin
        r_clean <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      r_rise <= w_done & r_s2;
    end
  end

  assign o_clean    = r_clean;
  assign o_rise     = r_rise;
  assign o_rise_nxt = w_done & r_s2;

endmodule

// File: rtl/sensor_frontend.sv
// Sensor input front end: synchronise + debounce 4 pins, emit clean levels, rise pulses, sticky flags.
// Latency: raw change at edge k -> clean_o/rise_o/event_o at edge k+DEB_CYCLES+1; latched_o same edge as rise.
// Backpressure: none; all outputs registered, no combinational input-to-output path.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   raw_i[3:0] : async pins [0] armed, [1] door, [2] motion, [3] temp
//   ack_i      : clears sticky flags (only with SENSOR_LATCH_EN)
//   clean_o    : debounced levels
//   rise_o     : one-cycle pulse per clean 0->1 transition
//   latched_o  : sticky rise flags with SENSOR_LATCH_EN, otherwise a copy of clean_o
//   event_o    : OR of rise_o, same timing
// Build option: define SENSOR_LATCH_EN to enable the sticky flags and ack_i.
module sensor_frontend
  import sensor_pkg::*;
#(
  parameter int DEB_CYCLES = DEFAULT_DEB_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SENS-1:0] raw_i,
  input  logic              ack_i,
  output logic [N_SENS-1:0] clean_o,
  output logic [N_SENS-1:0] rise_o,
  output logic [N_SENS-1:0] latched_o,
  output logic              event_o
);

  logic [N_SENS-1:0] w_clean;
  logic [N_SENS-1:0] w_rise;
  logic [N_SENS-1:0] w_rise_nxt;
  logic              r_event;

  for (genvar g = 0; g < N_SENS; g++) begin : g_chan
    sensor_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk        (clk),
      .rst        (rst),
      .i_raw      (raw_i[g]),
      .o_clean    (w_clean[g]),
      .o_rise     (w_rise[g]),
      .o_rise_nxt (w_rise_nxt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_event <= 1'b0;
    end else begin
      r_event <= |w_rise_nxt;
    end
  end

`ifdef SENSOR_LATCH_EN
  logic [N_SENS-1:0] r_latched;

  // Set takes priority over ack so a rise coinciding with ack is never lost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_latched <= '0;
    end else begin
      r_latched <= (r_latched & ~{N_SENS{ack_i}}) | w_rise_nxt;
    end
  end

  assign latched_o = r_latched;
`else
  logic w_ack_unused;

  assign w_ack_unused = ack_i;
  assign latched_o    = w_clean;
`endif

  assign clean_o = w_clean;
  assign rise_o  = w_rise;
  assign event_o = r_event;

endmodule
